// File: rtl/uart_print_sched.sv
// uart_print_sched: round-robin message arbiter for three byte printers feeding one 8N1 UART transmitter
module uart_print_sched #(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 115200,
  parameter int TIMEOUT  = 65536
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  req_valid,
  input  logic [23:0] req_data,
  input  logic [2:0]  req_last,
  output logic [2:0]  req_ready,
  output logic [2:0]  grant,
  output logic        busy,
  output logic        timeout_pulse,
  output logic        uart_tx
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  state_t          r_state, w_state_n;
  logic [BW-1:0]   r_baud;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift, w_shift_n, w_sel_data;
  logic            r_tx, w_tx_n;
  logic [2:0]      r_grant, w_pick;
  logic [1:0]      r_last, w_gidx;
  logic [SW-1:0]   r_stall;
  logic            r_to;
  logic            w_idle, w_baud_end, w_accept, w_sel_valid, w_sel_last, w_stall, w_expire;
  assign w_idle      = r_state == S_IDLE;
  assign w_baud_end  = r_baud == BW'(DIV - 1);
  assign req_ready   = r_grant & {3{w_idle}};
  assign w_accept    = |(req_valid & req_ready);
  assign w_sel_valid = |(req_valid & r_grant);
  assign w_sel_last  = |(req_last & r_grant);
  assign w_gidx      = r_grant[0] ? 2'd0 : r_grant[1] ? 2'd1 : 2'd2;
  assign w_sel_data  = r_grant[0] ? req_data[7:0] : r_grant[1] ? req_data[15:8] : req_data[23:16];
  assign w_stall     = |r_grant && w_idle && !w_sel_valid;
  assign w_expire    = w_stall && r_stall == SW'(TIMEOUT - 1);
  assign w_pick      = r_last == 2'd0 ? (req_valid[1] ? 3'b010 : req_valid[2] ? 3'b100 : req_valid[0] ? 3'b001 : 3'b000) :
                       r_last == 2'd1 ? (req_valid[2] ? 3'b100 : req_valid[0] ? 3'b001 : req_valid[1] ? 3'b010 : 3'b000) :
                                        (req_valid[0] ? 3'b001 : req_valid[1] ? 3'b010 : req_valid[2] ? 3'b100 : 3'b000);
  assign grant         = r_grant;
  assign busy          = |r_grant || !w_idle;
  assign timeout_pulse = r_to;
  assign uart_tx       = r_tx;
  // serializer next state, shift register and line level derived from the next state
  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    case (r_state)
      S_IDLE:  if (w_accept) begin
                 w_state_n = S_START;
                 w_shift_n = w_sel_data;
               end
      S_START: if (w_baud_end) w_state_n = S_DATA;
      S_DATA:  if (w_baud_end) begin
                 w_shift_n = r_shift >> 1;
                 if (r_bit == 3'd7) w_state_n = S_STOP;
               end
      S_STOP:  if (w_baud_end) w_state_n = S_IDLE;
    endcase
    w_tx_n = w_state_n == S_START ? 1'b0 : w_state_n == S_DATA ? w_shift_n[0] : 1'b1;
  end
  // serializer state, baud and bit counters; reset aborts any frame and idles the line
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
      r_baud  <= (w_idle || w_baud_end) ? '0 : r_baud + BW'(1);
      r_bit   <= r_state != S_DATA ? 3'd0 : w_baud_end ? r_bit + 3'd1 : r_bit;
    end
  end
  // message-granular grant, round-robin pointer and stall watchdog; an accepted byte beats expiry
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_grant <= '0;
      r_last  <= 2'd2;
      r_stall <= '0;
      r_to    <= 1'b0;
    end else begin
      r_to    <= w_expire;
      r_stall <= (w_accept || !(|r_grant) || w_expire) ? '0 : w_stall ? r_stall + SW'(1) : r_stall;
      if (|r_grant) begin
        if ((w_accept && w_sel_last) || w_expire) begin
          r_grant <= '0;
          r_last  <= w_gidx;
        end
      end else begin
        r_grant <= w_pick;
      end
    end
  end
endmodule

// File: tb/tb_uart_print_sched.sv
// tb_uart_print_sched: table-driven and hand-sequenced checks with a UART frame scoreboard
module tb_uart_print_sched;
  localparam int DIV = 104;
  localparam int FL  = 10 * DIV;
  localparam int TMO = 300;
  typedef struct {
    int         grp;
    int         req;
    logic [7:0] data;
    logic       last;
  } vec_t;
  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  req_valid, req_last, req_ready, grant;
  logic [23:0] req_data;
  logic        busy, timeout_pulse, uart_tx;
  logic [2:0]  f_valid, f_last, f_ready, f_grant;
  logic [23:0] f_data;
  logic        f_busy, f_to, f_tx;
  vec_t        vt [9];
  logic [7:0]  exp_q [$];
  logic [8:0]  dq0 [$], dq1 [$], dq2 [$];
  logic        mon_s [0:FL-1];
  int          mon_cnt, n_vec, n_err, rdy_hi, n, t, g, c, cnt;
  logic [2:0]  acc;
  logic        auto_drv, vio;
  logic [39:0] fs, fe;
  logic [9:0]  fb;

  always #5 clk = ~clk;

  uart_print_sched #(.TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse), .uart_tx(uart_tx)
  );

  uart_print_sched #(.BAUD(3000000), .TIMEOUT(64)) fast (
    .clk(clk), .resetn(resetn), .req_valid(f_valid), .req_data(f_data), .req_last(f_last),
    .req_ready(f_ready), .grant(f_grant), .busy(f_busy), .timeout_pulse(f_to), .uart_tx(f_tx)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic mon_finish();
    logic [9:0] b;
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      b[k] = mon_s[k*DIV];
      for (int j = 1; j < DIV; j++) if (mon_s[k*DIV+j] !== b[k]) ok = 1'b0;
    end
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_unexpected got=%0h exp=none", b[8:1]);
    end else begin
      chk("frame", {ok & ~b[0] & b[9], b[8:1]}, {1'b1, exp_q.pop_front()});
    end
  endtask

  task automatic drive();
    logic [8:0] e0, e1, e2;
    if (acc[0] && dq0.size() != 0) void'(dq0.pop_front());
    if (acc[1] && dq1.size() != 0) void'(dq1.pop_front());
    if (acc[2] && dq2.size() != 0) void'(dq2.pop_front());
    e0 = dq0.size() != 0 ? dq0[0] : 9'h0;
    e1 = dq1.size() != 0 ? dq1[0] : 9'h0;
    e2 = dq2.size() != 0 ? dq2[0] : 9'h0;
    req_valid = {dq2.size() != 0, dq1.size() != 0, dq0.size() != 0};
    req_data  = {e2[7:0], e1[7:0], e0[7:0]};
    req_last  = {e2[8], e1[8], e0[8]};
  endtask

  task automatic step();
    @(negedge clk);
    acc = resetn ? (req_valid & req_ready) : 3'b000;
    if (req_ready != 0) rdy_hi++;
    if ((req_ready & ~grant) != 0 || (grant & (grant - 3'd1)) != 0) vio = 1'b1;
    if (!resetn) mon_cnt = 0;
    else if (mon_cnt > 0 || !uart_tx) begin
      mon_s[mon_cnt] = uart_tx;
      mon_cnt++;
      if (mon_cnt == FL) begin
        mon_finish();
        mon_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
    if (auto_drv) drive();
  endtask

  task automatic wait_acc(input logic [2:0] m, output int gg);
    gg = 0;
    do begin
      step();
      gg++;
    end while ((acc & m) == 0 && gg < 3*FL);
  endtask

  task automatic wait_idle(output int tt);
    tt = 0;
    while (busy && tt < 8*FL) begin
      tt++;
      step();
    end
  endtask

  initial begin
    vt = '{'{0, 0, 8'hA0, 1'b0}, '{0, 0, 8'hA1, 1'b1}, '{0, 1, 8'hB0, 1'b0}, '{0, 1, 8'hB1, 1'b1},
           '{0, 2, 8'hC0, 1'b0}, '{0, 2, 8'hC1, 1'b1}, '{1, 1, 8'h00, 1'b0}, '{1, 1, 8'hFF, 1'b1},
           '{1, 2, 8'h5A, 1'b1}};
    n_vec = 0; n_err = 0; mon_cnt = 0; rdy_hi = 0; vio = 1'b0; auto_drv = 1'b0; acc = '0;
    resetn = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    f_valid = '0; f_data = '0; f_last = '0;
    repeat (3) step();
    chk("rst_grant", grant, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx", uart_tx, 1);
    chk("rst_pulse", timeout_pulse, 0);
    chk("rst_fast_tx", f_tx, 1);
    resetn = 1'b1;
    step();
    chk("idle_grant", grant, 0);
    // single byte 0x41 from requester 0
    req_valid = 3'b001; req_data = 24'h41; req_last = 3'b001;
    exp_q.push_back(8'h41);
    step();
    chk("b41_grant", grant, 3'b001);
    chk("b41_ready", req_ready, 3'b001);
    step();
    chk("b41_acc", acc, 3'b001);
    chk("b41_grant_clr", grant, 0);
    chk("b41_busy", busy, 1);
    chk("b41_start", uart_tx, 0);
    req_valid = '0;
    n = 0;
    while (uart_tx == 1'b0 && n < 2*DIV) begin
      n++;
      step();
    end
    chk("b41_start_len", n, DIV);
    t = n;
    while (busy && t < 2*FL) begin
      t++;
      step();
    end
    chk("b41_frame_len", t, FL);
    chk("b41_sb_empty", exp_q.size(), 0);
    // round-robin message groups from the table
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    for (int gi = 0; gi < 2; gi++) begin
      cnt = 0;
      for (int i = 0; i < 9; i++) begin
        if (vt[i].grp == gi) begin
          case (vt[i].req)
            0: dq0.push_back({vt[i].last, vt[i].data});
            1: dq1.push_back({vt[i].last, vt[i].data});
            default: dq2.push_back({vt[i].last, vt[i].data});
          endcase
          exp_q.push_back(vt[i].data);
          cnt++;
        end
      end
      auto_drv = 1'b1;
      acc = '0;
      drive();
      n = 0;
      while (uart_tx && n < 20) begin
        n++;
        step();
      end
      chk("grp_latency", n, 2);
      wait_idle(t);
      chk("grp_len", t, cnt*FL + cnt - 1);
      chk("grp_drained", dq0.size() + dq1.size() + dq2.size() + exp_q.size(), 0);
      auto_drv = 1'b0;
    end
    // same byte held valid across frames, then a closing byte
    req_valid = 3'b001; req_data = 24'h3C; req_last = 3'b000;
    exp_q.push_back(8'h3C); exp_q.push_back(8'h3C); exp_q.push_back(8'hC3);
    wait_acc(3'b001, g);
    chk("hold_arb_lat", g, 2);
    rdy_hi = 0;
    wait_acc(3'b001, g);
    chk("hold_gap", g, FL + 1);
    chk("hold_rdy_cycles", rdy_hi, 1);
    req_data = 24'hC3; req_last = 3'b001;
    wait_acc(3'b001, g);
    chk("hold_gap2", g, FL + 1);
    req_valid = '0;
    wait_idle(t);
    chk("hold_tail", t, FL);
    // accepted byte on the expiry edge beats the timeout
    req_valid = 3'b001; req_data = 24'h5E; req_last = 3'b000;
    exp_q.push_back(8'h5E);
    wait_acc(3'b001, g);
    req_valid = '0;
    c = 0; n = 0;
    while (c < FL + TMO - 1) begin
      step();
      c++;
      if (timeout_pulse) n++;
    end
    chk("prec_no_early_pulse", n, 0);
    req_valid = 3'b001; req_data = 24'hE5; req_last = 3'b000;
    exp_q.push_back(8'hE5);
    step();
    chk("prec_acc", acc, 3'b001);
    chk("prec_grant_kept", grant, 3'b001);
    chk("prec_no_pulse", timeout_pulse, 0);
    req_data = 24'h7E; req_last = 3'b001;
    exp_q.push_back(8'h7E);
    wait_acc(3'b001, g);
    req_valid = '0;
    wait_idle(t);
    // requester 1 stalls mid-message and loses the grant
    req_valid = 3'b110; req_data = 24'h22_11_00; req_last = 3'b100;
    exp_q.push_back(8'h11);
    step();
    chk("to_grant1", grant, 3'b010);
    step();
    chk("to_acc1", acc, 3'b010);
    req_valid = 3'b100;
    c = 0;
    while (!timeout_pulse && c < FL + TMO + 50) begin
      step();
      c++;
    end
    chk("to_time", c, FL + TMO);
    chk("to_grant_clr", grant, 0);
    exp_q.push_back(8'h22);
    step();
    chk("to_pulse_once", timeout_pulse, 0);
    chk("to_next_grant", grant, 3'b100);
    wait_acc(3'b100, g);
    chk("to_acc2", g, 1);
    req_valid = '0;
    wait_idle(t);
    chk("to_tail", t, FL);
    // reset in the middle of a frame
    req_valid = 3'b001; req_data = 24'h55; req_last = 3'b001;
    wait_acc(3'b001, g);
    req_valid = '0;
    repeat (300) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("mid_rst_tx", uart_tx, 1);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    req_valid = 3'b001; req_data = 24'h96; req_last = 3'b001;
    exp_q.push_back(8'h96);
    wait_acc(3'b001, g);
    chk("post_rst_lat", g, 2);
    req_valid = '0;
    wait_idle(t);
    chk("post_rst_len", t, FL);
    // fast baud instance: four cycles per bit
    f_valid = 3'b001; f_data = 24'hA5; f_last = 3'b001;
    step();
    chk("fast_ready", f_ready, 3'b001);
    step();
    chk("fast_grant_clr", f_grant, 0);
    f_valid = '0;
    fb = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 40; k++) begin
      fs[k] = f_tx;
      fe[k] = fb[k/4];
      step();
    end
    chk("fast_frame", fs, fe);
    chk("fast_idle", f_busy, 0);
    chk("fast_line_idle", f_tx, 1);
    chk("ready_onehot", vio, 0);
    chk("sb_final", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
